// File: rtl/dly_seq_ctrl.sv
// rtl/dly_seq_ctrl.sv - run controller for the tapped-delay marker datapath
//
// Generates a periodic marker for a latched number of frames, shifts it
// through a DEPTH-stage delay line, reports two tap coincidences, then
// drains the line and pulses done.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               run request, sampled only in IDLE
//   stop_i                abort request, sampled only in RUN
//   period_i, hi_len_i    frame length / mark-high cycles per frame
//   n_frames_i            frames per run, 0 runs until stop
//   tap_a_i/b_i/c_i       delay-line taps, values >= DEPTH read as 0
//   busy_o                high in RUN and DRAIN
//   mark_o, valid_o       marker and its complement (RUN only)
//   y1_o, y2_o            line[a]&line[b], line[a]&line[c]
//   frame_cnt_o           frames completed in the current/last run
//   done_o, err_o         end-of-run pulse, rejected-start pulse
module dly_seq_ctrl #(
  parameter int PERIOD_W = 8,
  parameter int DEPTH    = 16,
  parameter int TAP_W    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [PERIOD_W-1:0] hi_len_i,
  input  logic [CNT_W-1:0]    n_frames_i,
  input  logic [TAP_W-1:0]    tap_a_i,
  input  logic [TAP_W-1:0]    tap_b_i,
  input  logic [TAP_W-1:0]    tap_c_i,
  output logic                busy_o,
  output logic                mark_o,
  output logic                valid_o,
  output logic                y1_o,
  output logic                y2_o,
  output logic [CNT_W-1:0]    frame_cnt_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam int DC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t              state_q;
  logic [PERIOD_W-1:0] phase_q, period_q, hi_len_q;
  logic [CNT_W-1:0]    n_frames_q, frame_cnt_q;
  logic [TAP_W-1:0]    tap_a_q, tap_b_q, tap_c_q;
  logic [DC_W-1:0]     drain_q;
  logic [DEPTH-1:0]    line_q;
  logic                busy_q, mark_q, valid_q, done_q, err_q;

  logic [PERIOD_W-1:0] phase_d;
  logic [CNT_W-1:0]    frame_cnt_d;
  logic [DEPTH-1:0]    line_d;
  logic                wrap, run_end, cfg_bad, mark_d;
  logic [(2**TAP_W)-1:0] line_ext;

  always_comb begin
    wrap        = (phase_q == period_q - 1'b1);
    phase_d     = wrap ? '0 : phase_q + 1'b1;
    frame_cnt_d = frame_cnt_q + 1'b1;
    mark_d      = (phase_d < hi_len_q);
    // The last-frame wrap and a stop both end the run; a coincident stop
    // still lets the wrap count the frame.
    run_end     = stop_i || (wrap && (n_frames_q != '0) && (frame_cnt_d == n_frames_q));
    cfg_bad     = (period_i < PERIOD_W'(2)) || (hi_len_i == '0) || (hi_len_i >= period_i);
    // Only RUN feeds the marker in; DRAIN and IDLE shift zeros so the
    // line is empty by the time the run reports done.
    line_d      = line_q << 1;
    line_d[0]   = (state_q == S_RUN) ? mark_q : 1'b0;
    // Zero-extend the line so out-of-range taps read constant 0.
    line_ext               = '0;
    line_ext[DEPTH-1:0]    = line_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      period_q    <= '0;
      hi_len_q    <= '0;
      n_frames_q  <= '0;
      frame_cnt_q <= '0;
      tap_a_q     <= '0;
      tap_b_q     <= '0;
      tap_c_q     <= '0;
      drain_q     <= '0;
      line_q      <= '0;
      busy_q      <= 1'b0;
      mark_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      line_q <= line_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            period_q   <= period_i;
            hi_len_q   <= hi_len_i;
            n_frames_q <= n_frames_i;
            tap_a_q    <= tap_a_i;
            tap_b_q    <= tap_b_i;
            tap_c_q    <= tap_c_i;
            if (cfg_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= S_RUN;
              phase_q     <= '0;
              frame_cnt_q <= '0;
              busy_q      <= 1'b1;
              // Phase 0 always has mark high since hi_len >= 1.
              mark_q      <= 1'b1;
              valid_q     <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (wrap) frame_cnt_q <= frame_cnt_d;
          if (run_end) begin
            state_q <= S_DRAIN;
            drain_q <= '0;
            mark_q  <= 1'b0;
            valid_q <= 1'b0;
          end else begin
            phase_q <= phase_d;
            mark_q  <= mark_d;
            valid_q <= ~mark_d;
          end
        end
        S_DRAIN: begin
          if (drain_q == DC_W'(DEPTH - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign mark_o      = mark_q;
  assign valid_o     = valid_q;
  assign y1_o        = line_ext[tap_a_q] & line_ext[tap_b_q];
  assign y2_o        = line_ext[tap_a_q] & line_ext[tap_c_q];
  assign frame_cnt_o = frame_cnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: doc/dly_seq_ctrl.md
# dly_seq_ctrl

Run controller for the tapped-delay marker datapath. It generates a programmable periodic marker (`mark`/`valid`), shifts `mark` through a DEPTH-stage delay line, and produces two tap-coincidence outputs. It runs a requested number of frames under a start/stop handshake, then drains the line and signals completion. It sits between the control/register logic and the coincidence-detect consumers.

## Interface
- `PERIOD_W`, default 8: width of `period` and `hi_len`, and of the phase counter.
- `DEPTH`, default 16: delay-line stages. Must be ≤ 2^TAP_W.
- `TAP_W`, default 4: tap index width.
- `CNT_W`, default 16: width of the frame count.

- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `start` input, 1: one-cycle run request. Sampled only in IDLE.
- `stop` input, 1: abort request. Sampled only in RUN.
- `period` input, PERIOD_W: frame length in cycles. Legal range 2..2^PERIOD_W−1.
- `hi_len` input, PERIOD_W: `mark`-high cycles per frame. Legal range 1..period−1.
- `n_frames` input, CNT_W: frames to run. 0 means run until `stop`.
- `tap_a`, `tap_b`, `tap_c` input, TAP_W each: delay-line tap indices. Values ≥ DEPTH select constant 0.
- `busy` output, 1: high in RUN and DRAIN.
- `mark` output, 1: marker, high for phase < hi_len.
- `valid` output, 1: equals `~mark` in RUN; 0 otherwise.
- `y1` output, 1: `line[tap_a] & line[tap_b]`.
- `y2` output, 1: `line[tap_a] & line[tap_c]`.
- `frame_cnt` output, CNT_W: frames completed in the current run.
- `done` output, 1: one-cycle pulse at the end of a run.
- `err` output, 1: one-cycle pulse when a start is rejected.

## Operation
- States are IDLE, RUN and DRAIN. Reset enters IDLE and clears the phase counter, `frame_cnt`, the drain counter, the delay line, and all outputs to 0.
- **IDLE, on `start`:**
  - Latch `period`, `hi_len`, `n_frames`, `tap_a`, `tap_b` and `tap_c`. Later input changes are ignored until the next start.
  - If `period` < 2, `hi_len` == 0, or `hi_len` ≥ `period`: pulse `err` and stay in IDLE.
  - Otherwise: set phase to 0, clear `frame_cnt`, and go to RUN.
- **RUN:**
  - Phase counts 0..period−1, then wraps.
  - `mark` = (phase < hi_len); `valid` = ~mark.
  - At phase == period−1, `frame_cnt` increments.
  - If n_frames ≠ 0 and the incremented count equals n_frames, go to DRAIN on that same edge.
- **`stop` in RUN:** go to DRAIN on the next edge. The partial frame is not counted. If `stop` coincides with the last-frame wrap, the result is the same (DRAIN), and that frame is counted.
- **Delay line:**
  - In RUN: `line[0] <= mark`, `line[k] <= line[k−1]`.
  - In DRAIN: a 0 is shifted into `line[0]`.
  - In IDLE: the line holds all zeros.
- **DRAIN:**
  - `mark` = 0 and `valid` = 0.
  - Lasts exactly DEPTH cycles, counted by the drain counter.
  - On the last DRAIN cycle the next state is IDLE and `done` is registered high. `done` is therefore visible in the first IDLE cycle.
- `start` while busy is ignored: no `err`, no reload.
- `frame_cnt` holds its final value in IDLE until the next accepted start.

## Timing
- Start accepted at edge t: `busy`, `mark` and `valid` reflect RUN from cycle t+1, with phase 0 in cycle t+1.
- `line[k]` equals `mark` delayed k+1 cycles.
- `y1` and `y2` are combinational from the line registers; there is no extra latency.
- `err` is high in cycle t+1 only.
- With n_frames = N, period = P and the start accepted at t:
  - RUN occupies cycles t+1 .. t+N·P.
  - DRAIN occupies cycles t+N·P+1 .. t+N·P+DEPTH.
  - `done` is high in cycle t+N·P+DEPTH+1, which is also the first cycle with `busy` = 0.
- `stop` sampled at edge s: DRAIN starts at cycle s+1.
- `rst` asserted at any time forces IDLE and all-zero outputs immediately (asynchronous). No `done` pulse is produced.

## Test plan
- **Basic run:** period=4, hi_len=2, n_frames=3, taps a=0, b=4, c=15, start at t=0.
  - `mark` is high in cycles 1,2,5,6,9,10.
  - `y1` is high in cycles 6,7,10,11 only.
  - `y2` is always 0.
  - `frame_cnt` ends at 3.
  - `busy` is high in cycles 1..28; `done` pulses in cycle 29.
- **Illegal config:** period=1, then hi_len=4 with period=4, each with a start → `err` pulse in the next cycle, `busy` stays 0, `frame_cnt` is unchanged.
- **Free run and stop:** n_frames=0, period=5, hi_len=1, then `stop` in cycle 12 → `frame_cnt` = 2, DRAIN lasts 16 cycles, then a single `done` pulse.
- **Start while busy:** a second start with different `period` mid-run → ignored; the mark pattern and the end cycle are unchanged.
- **Reset mid-run:** assert `rst` in cycle 7 of the basic run → all outputs 0 immediately, no `done`. A new start after reset release runs normally.
- **Out-of-range tap:** tap_b=15 with DEPTH=12 → `y1` stays 0 for the whole run.
